// File: rtl/pll_seq_pkg.sv
// Shared types and widths for the PLL reset sequencer.
// Included by pll_reset_sequencer and its testbench.
package pll_seq_pkg;

    typedef enum logic [1:0] {
        HOLD,
        WAIT_LOCK,
        LOCKED,
        FAIL
    } pll_seq_state_t;

    localparam int RETRY_W = 8;
    localparam int STAT_W  = 8;

endpackage

// File: rtl/pll_reset_sequencer_sync_2ff.sv
// Two-flop synchronizer for the asynchronous PLL LOCK output.
// Synchronous active-low reset clears both stages to 0.
module sync_2ff (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk) begin
        if (!reset) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/pll_reset_sequencer.sv
// Power-up / recovery sequencer for SB_PLL40_CORE RESETB and BYPASS.
// Optional macro PLL_SEQ_STATUS_EN adds the lock_loss_cnt status port.
module pll_reset_sequencer
    import pll_seq_pkg::*;
#(
    parameter int RESET_CYCLES   = 16,
    parameter int LOCK_STABLE    = 64,
    parameter int LOCK_TIMEOUT   = 4096,
    parameter int MAX_RETRIES    = 3,
    parameter int BYPASS_ON_FAIL = 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               lock_in,
    output logic               pll_resetb,
    output logic               pll_bypass,
    output logic               pll_ready,
    output logic               pll_fail,
    output logic [RETRY_W-1:0] retry_count
`ifdef PLL_SEQ_STATUS_EN
    ,
    output logic [STAT_W-1:0]  lock_loss_cnt
`endif
);

    localparam int HOLD_W = $clog2(RESET_CYCLES + 1);
    localparam int STB_W  = $clog2(LOCK_STABLE + 1);
    localparam int TMO_W  = $clog2(LOCK_TIMEOUT + 1);

    localparam logic [HOLD_W-1:0]  HOLD_LAST  = HOLD_W'(RESET_CYCLES - 1);
    localparam logic [STB_W-1:0]   STB_LAST   = STB_W'(LOCK_STABLE - 1);
    localparam logic [TMO_W-1:0]   TMO_LAST   = TMO_W'(LOCK_TIMEOUT - 1);
    localparam logic [RETRY_W-1:0] RETRY_LAST = RETRY_W'(MAX_RETRIES);
    localparam logic               BYP        = (BYPASS_ON_FAIL != 0);

    pll_seq_state_t    state;
    logic [HOLD_W-1:0] hold_cnt;
    logic [STB_W-1:0]  stb_cnt;
    logic [TMO_W-1:0]  tmo_cnt;
    logic              lock_s;
    logic              lock_ok;
    logic              tmo_done;
    logic              drop;

    sync_2ff u_sync (
        .clk   (clk),
        .reset (reset),
        .d     (lock_in),
        .q     (lock_s)
    );

    // Lock qualification has priority over the attempt timeout.
    assign lock_ok  = lock_s && (stb_cnt == STB_LAST);
    assign tmo_done = (tmo_cnt == TMO_LAST);
    assign drop     = ((state == WAIT_LOCK) && !lock_ok && tmo_done) ||
                      ((state == LOCKED) && !lock_s);

    always_ff @(posedge clk) begin
        if (!reset) begin
            state       <= HOLD;
            hold_cnt    <= '0;
            stb_cnt     <= '0;
            tmo_cnt     <= '0;
            retry_count <= '0;
            pll_resetb  <= 1'b0;
            pll_bypass  <= 1'b0;
            pll_ready   <= 1'b0;
            pll_fail    <= 1'b0;
        end else begin
            unique case (state)
                HOLD: begin
                    if (hold_cnt == HOLD_LAST) begin
                        state      <= WAIT_LOCK;
                        hold_cnt   <= '0;
                        pll_resetb <= 1'b1;
                    end else begin
                        hold_cnt <= hold_cnt + 1'b1;
                    end
                end
                WAIT_LOCK: begin
                    tmo_cnt <= tmo_cnt + 1'b1;
                    stb_cnt <= lock_s ? stb_cnt + 1'b1 : '0;
                    if (lock_ok) begin
                        state       <= LOCKED;
                        retry_count <= '0;
                        pll_ready   <= 1'b1;
                        tmo_cnt     <= '0;
                        stb_cnt     <= '0;
                    end
                end
                LOCKED: begin
                end
                FAIL: begin
                end
            endcase

            // Lock timeout or lock loss: re-reset the PLL or give up.
            if (drop) begin
                hold_cnt   <= '0;
                tmo_cnt    <= '0;
                stb_cnt    <= '0;
                pll_resetb <= 1'b0;
                pll_ready  <= 1'b0;
                if (retry_count == RETRY_LAST) begin
                    state      <= FAIL;
                    pll_fail   <= 1'b1;
                    pll_bypass <= BYP;
                    pll_ready  <= BYP;
                end else begin
                    state       <= HOLD;
                    retry_count <= retry_count + 1'b1;
                end
            end
        end
    end

`ifdef PLL_SEQ_STATUS_EN
    always_ff @(posedge clk) begin
        if (!reset) begin
            lock_loss_cnt <= '0;
        end else if ((state == LOCKED) && !lock_s && (lock_loss_cnt != '1)) begin
            lock_loss_cnt <= lock_loss_cnt + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Self-checking bench for pll_reset_sequencer: vector table, directed
// corner sequences and random lock_in against a phase/age reference model.
module tb_pll_reset_sequencer;

    localparam int RC = 4;
    localparam int LS = 8;
    localparam int LT = 32;
    localparam int MR = 2;
    localparam int BF = 1;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       lock_in = 1'b0;
    logic       pll_resetb;
    logic       pll_bypass;
    logic       pll_ready;
    logic       pll_fail;
    logic [7:0] retry_count;
`ifdef PLL_SEQ_STATUS_EN
    logic [7:0] lock_loss_cnt;
`endif

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    pll_reset_sequencer #(
        .RESET_CYCLES   (RC),
        .LOCK_STABLE    (LS),
        .LOCK_TIMEOUT   (LT),
        .MAX_RETRIES    (MR),
        .BYPASS_ON_FAIL (BF)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .lock_in       (lock_in),
        .pll_resetb    (pll_resetb),
        .pll_bypass    (pll_bypass),
        .pll_ready     (pll_ready),
        .pll_fail      (pll_fail),
        .retry_count   (retry_count)
`ifdef PLL_SEQ_STATUS_EN
        ,
        .lock_loss_cnt (lock_loss_cnt)
`endif
    );

    // Reference model: phase 0 reset pulse, 1 waiting, 2 locked, 3 failed.
    // age = edges since phase entry, run = trailing synced ones this attempt.
    int ph;
    int age;
    int run;
    int retries;
    int losses;
    int k;
    bit dly[$];

    task automatic model_step(input bit r, input bit l);
        bit seen;
        if (!r) begin
            ph = 0; age = 0; run = 0; retries = 0; losses = 0;
            dly = '{1'b0, 1'b0};
            return;
        end
        seen = dly.pop_front();
        dly.push_back(l);
        if (ph == 0) begin
            if (age + 1 >= RC) begin
                ph = 1; age = 0; run = 0;
            end else begin
                age++;
            end
        end else if (ph == 1) begin
            age++;
            run = seen ? run + 1 : 0;
            if (run >= LS) begin
                ph = 2; retries = 0;
            end else if (age >= LT) begin
                if (retries == MR) ph = 3;
                else begin ph = 0; age = 0; retries++; end
            end
        end else if (ph == 2) begin
            if (!seen) begin
                if (losses < 255) losses++;
                if (retries == MR) ph = 3;
                else begin ph = 0; age = 0; retries++; end
            end
        end
    endtask

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (k=%0d t=%0t)",
                     name, act, exp, k, $time);
        end
    endtask

    task automatic tick();
        logic [11:0] e;
        @(posedge clk);
        #1;
        model_step(reset, lock_in);
        k = reset ? k + 1 : 0;
        e = {(ph == 1 || ph == 2), (ph == 3 && BF != 0),
             (ph == 2 || (ph == 3 && BF != 0)), (ph == 3), retries[7:0]};
        check("model", {pll_resetb, pll_bypass, pll_ready, pll_fail,
                        retry_count}, {20'd0, e});
`ifdef PLL_SEQ_STATUS_EN
        check("loss_model", lock_loss_cnt, losses);
`endif
    endtask

    task automatic do_reset(input bit l);
        reset = 1'b0;
        lock_in = l;
        tick();
        reset = 1'b1;
    endtask

    task automatic step_to(input int n);
        for (int g = 0; g < 100000 && k < n; g++) tick();
    endtask

`ifdef PLL_SEQ_STATUS_EN
    task automatic lose_once();
        int g;
        lock_in = 1'b1;
        for (g = 0; g < 200 && !pll_ready; g++) tick();
        check("relock_wait", pll_ready, 1);
        lock_in = 1'b0;
        for (g = 0; g < 10 && pll_ready; g++) tick();
        check("loss_wait", pll_ready, 0);
    endtask
`endif

    typedef struct {
        bit         lock;
        bit         e_resetb;
        bit         e_ready;
        logic [7:0] e_retry;
    } vec_t;

    vec_t vt[16];

    initial begin
        for (int i = 0; i < 16; i++)
            vt[i] = '{1'b1, (i + 1) >= 4, (i + 1) >= 12, 8'd0};

        // Reset values
        do_reset(1'b1);
        check("rst_outs", {pll_resetb, pll_bypass, pll_ready, pll_fail,
                           retry_count}, 0);

        // Clean power-up with lock held high
        for (int i = 0; i < 16; i++) begin
            lock_in = vt[i].lock;
            tick();
            check("t1_resetb", pll_resetb, vt[i].e_resetb);
            check("t1_ready", pll_ready, vt[i].e_ready);
            check("t1_retry", retry_count, vt[i].e_retry);
        end

        // One-cycle lock glitch restarts qualification
        do_reset(1'b1);
        step_to(7);
        lock_in = 1'b0;
        step_to(8);
        lock_in = 1'b1;
        step_to(12);
        check("t2_ready12", pll_ready, 0);
        step_to(17);
        check("t2_ready17", pll_ready, 0);
        step_to(18);
        check("t2_ready18", pll_ready, 1);

        // No lock ever: three attempts then FAIL
        do_reset(1'b0);
        step_to(3);
        check("t3_rb3", pll_resetb, 0);
        step_to(4);
        check("t3_rb4", pll_resetb, 1);
        step_to(35);
        check("t3_retry35", retry_count, 0);
        step_to(36);
        check("t3_retry36", retry_count, 1);
        check("t3_rb36", pll_resetb, 0);
        step_to(39);
        check("t3_rb39", pll_resetb, 0);
        step_to(40);
        check("t3_rb40", pll_resetb, 1);
        step_to(72);
        check("t3_retry72", retry_count, 2);
        step_to(107);
        check("t3_fail107", pll_fail, 0);
        step_to(108);
        check("t3_fail108", {pll_fail, pll_bypass, pll_ready, pll_resetb},
              4'b1110);
        lock_in = 1'b1;
        step_to(160);
        check("t3_fail160", {pll_fail, pll_bypass, pll_ready, pll_resetb},
              4'b1110);

        // Lock loss and recovery
        do_reset(1'b1);
        step_to(20);
        lock_in = 1'b0;
        step_to(22);
        check("t4_ready22", pll_ready, 1);
        lock_in = 1'b1;
        step_to(23);
        check("t4_ready23", pll_ready, 0);
        check("t4_retry23", retry_count, 1);
        check("t4_rb23", pll_resetb, 0);
        step_to(26);
        check("t4_rb26", pll_resetb, 0);
        step_to(27);
        check("t4_rb27", pll_resetb, 1);
        step_to(34);
        check("t4_ready34", pll_ready, 0);
        step_to(35);
        check("t4_ready35", pll_ready, 1);
        check("t4_retry35", retry_count, 0);

        // Lock and timeout on the same edge: lock wins
        do_reset(1'b0);
        step_to(26);
        lock_in = 1'b1;
        step_to(35);
        check("lw_ready35", pll_ready, 0);
        step_to(36);
        check("lw_ready36", pll_ready, 1);
        check("lw_retry36", retry_count, 0);

        // Reset pulse mid-WAIT_LOCK restarts the sequence
        do_reset(1'b1);
        step_to(8);
        reset = 1'b0;
        tick();
        check("t5_rst", {pll_resetb, pll_bypass, pll_ready, pll_fail,
                         retry_count}, 0);
        reset = 1'b1;
        step_to(3);
        check("t5_rb3", pll_resetb, 0);
        step_to(4);
        check("t5_rb4", pll_resetb, 1);
        step_to(11);
        check("t5_ready11", pll_ready, 0);
        step_to(12);
        check("t5_ready12", pll_ready, 1);

`ifdef PLL_SEQ_STATUS_EN
        do_reset(1'b1);
        for (int n = 0; n < 3; n++) lose_once();
        check("t6_loss3", lock_loss_cnt, 3);
        for (int n = 0; n < 297; n++) lose_once();
        check("t6_loss300", lock_loss_cnt, 255);
`endif

        // Random lock_in segments with occasional resets
        do_reset(1'b0);
        for (int s = 0; s < 200; s++) begin
            bit v;
            int len;
            v = 1'($urandom_range(0, 1));
            len = v ? int'($urandom_range(1, 40)) : int'($urandom_range(1, 12));
            if ($urandom_range(0, 24) == 0) do_reset(v);
            lock_in = v;
            repeat (len) tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
